load_store_unit: RTL and testbench

- Data-side responder for load/store instructions.
- Accepts the effective address from the ALU (rs1 + sign-extended I/S immediate), the store data from rs2, and funct3.
- Performs the access on an internal synchronous word-wide data RAM using byte enables for stores.
- Returns the loaded value aligned and sign- or zero-extended to 32 bits.
- Sits between the execute stage and writeback.

---
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Data-side load/store responder: one request per three cycles against an internal word-wide RAM,
// with byte-enable stores, aligned/extended loads and misalignment/illegal-funct3 error reporting.
module load_store_unit #(
    parameter int unsigned ADDR_BITS  = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int unsigned AW    = ADDR_BITS + 2;
    localparam int unsigned WORDS = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    ready_nxt;
    logic                    valid_nxt;

    logic                    we_q;
    logic [2:0]              funct3_q;
    logic [AW-1:0]           addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    logic                    err;
    logic [3:0]              be;
    logic [DATA_WIDTH-1:0]   wlanes;
    logic [DATA_WIDTH-1:0]   word;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;
    logic [DATA_WIDTH-1:0]   load_val;
    logic [ADDR_BITS-1:0]    word_idx;

    logic [DATA_WIDTH-1:0]   mem [0:WORDS-1];

    // Address bits above the RAM range are dropped, so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[DATA_WIDTH-1:AW];

    assign word_idx = addr_q[AW-1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready_nxt = 1'b0;
        valid_nxt = 1'b0;
        case (state)
            S_IDLE:   if (req_valid) state_nxt = S_ACCESS;
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        ready_nxt = (state_nxt == S_IDLE);
        valid_nxt = (state_nxt == S_RESP);
    end

    // Access legality, byte enables and lane replication for the captured request.
    always_comb begin
        err    = 1'b0;
        be     = 4'b0000;
        wlanes = wdata_q;
        case (funct3_q)
            3'b000: begin
                be     = 4'b0001 << addr_q[1:0];
                wlanes = {4{wdata_q[7:0]}};
            end
            3'b001: begin
                err    = addr_q[0];
                be     = 4'b0011 << addr_q[1:0];
                wlanes = {2{wdata_q[15:0]}};
            end
            3'b010: begin
                err = |addr_q[1:0];
                be  = 4'b1111;
            end
            3'b100:  err = we_q;
            3'b101:  err = we_q | addr_q[0];
            default: err = 1'b1;
        endcase
    end

    // Lane selection and sign/zero extension of the addressed word.
    always_comb begin
        word     = mem[word_idx];
        byte_sel = 8'(word >> {addr_q[1:0], 3'b000});
        half_sel = addr_q[1] ? word[31:16] : word[15:0];
        load_val = '0;
        case (funct3_q)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_val = word;
            3'b100:  load_val = {24'd0, byte_sel};
            3'b101:  load_val = {16'd0, half_sel};
            default: load_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (state == S_IDLE && req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[AW-1:0];
            wdata_q  <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            req_ready  <= ready_nxt;
            resp_valid <= valid_nxt;
            if (state == S_ACCESS) begin
                resp_rdata <= (err || we_q) ? '0 : load_val;
                resp_err   <= err;
            end
        end
    end

    // RAM is not reset; a low rst_n at the edge suppresses any pending write.
    always_ff @(posedge clk) begin
        if (rst_n && state == S_ACCESS && we_q && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][i*8 +: 8] <= wlanes[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: reset, round trips, extension, partial stores, errors,
// back-to-back handshake spacing and address wrap, all against hand-computed values.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    load_store_unit #(.ADDR_BITS(10), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request and return the response plus the accept-to-resp_valid latency.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
    endtask

    task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(we, f3, addr, wdata, rd, er, lat);
        chk({tag, "_lat"}, 32'(lat), 32'd2);
        chk({tag, "_rdata"}, rd, exp_rdata);
        chk({tag, "_err"}, 32'(er), 32'(exp_err));
    endtask

    initial begin
        int acc [3];
        int na;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);

        // Reset during ACCESS must abort the store.
        txn("pre_sw0", 1'b1, F_W, 32'h10, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F_W;
        req_addr   = 32'h10;
        req_wdata  = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_valid", 32'(resp_valid), 32'd0);
        txn("abort_lw", 1'b0, F_W, 32'h10, 32'h0, 32'h0, 1'b0);

        txn("rt_sw", 1'b1, F_W, 32'h1004, 32'h12345678, 32'h0, 1'b0);
        txn("rt_lw", 1'b0, F_W, 32'h1004, 32'h0, 32'h12345678, 1'b0);
        @(negedge clk);
        chk("pulse_width", 32'(resp_valid), 32'd0);

        txn("ext_sw",  1'b1, F_W,  32'h20, 32'h80FF7F01, 32'h0, 1'b0);
        txn("lb_23",   1'b0, F_B,  32'h23, 32'h0, 32'hFFFFFF80, 1'b0);
        txn("lbu_23",  1'b0, F_BU, 32'h23, 32'h0, 32'h00000080, 1'b0);
        txn("lh_22",   1'b0, F_H,  32'h22, 32'h0, 32'hFFFF80FF, 1'b0);
        txn("lhu_22",  1'b0, F_HU, 32'h22, 32'h0, 32'h000080FF, 1'b0);
        txn("lb_20",   1'b0, F_B,  32'h20, 32'h0, 32'h00000001, 1'b0);
        txn("lb_21",   1'b0, F_B,  32'h21, 32'h0, 32'h0000007F, 1'b0);
        txn("lh_20",   1'b0, F_H,  32'h20, 32'h0, 32'h00007F01, 1'b0);

        txn("ps_sw", 1'b1, F_W, 32'h30, 32'h0, 32'h0, 1'b0);
        txn("ps_sb", 1'b1, F_B, 32'h31, 32'h123456AA, 32'h0, 1'b0);
        txn("ps_sh", 1'b1, F_H, 32'h32, 32'h7777BEEF, 32'h0, 1'b0);
        txn("ps_lw", 1'b0, F_W, 32'h30, 32'h0, 32'hBEEFAA00, 1'b0);

        txn("err_lw_mis",  1'b0, F_W,    32'h2002, 32'h0, 32'h0, 1'b1);
        txn("err_pre_sw",  1'b1, F_W,    32'h40, 32'h55667788, 32'h0, 1'b0);
        txn("err_sh_mis",  1'b1, F_H,    32'h41, 32'h1111, 32'h0, 1'b1);
        txn("err_post_lw", 1'b0, F_W,    32'h40, 32'h0, 32'h55667788, 1'b0);
        txn("err_f011",    1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1'b1);
        txn("err_sbu",     1'b1, F_BU,   32'h40, 32'hFF, 32'h0, 1'b1);
        txn("err_lhu_mis", 1'b0, F_HU,   32'h41, 32'h0, 32'h0, 1'b1);
        txn("err_post2",   1'b0, F_W,    32'h40, 32'h0, 32'h55667788, 1'b0);

        // Continuous req_valid: accepts must be spaced exactly three cycles.
        acc = '{-100, -100, -100};
        na  = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = F_W;
        req_addr   = 32'h1004;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (req_ready && na < 3) begin
                acc[na] = cyc;
                na++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("held_gap1", 32'(acc[1] - acc[0]), 32'd3);
        chk("held_gap2", 32'(acc[2] - acc[1]), 32'd3);
        chk("held_data", resp_rdata, 32'h12345678);

        txn("wrap_sw", 1'b1, F_W, 32'h1000, 32'hCAFEF00D, 32'h0, 1'b0);
        txn("wrap_lw", 1'b0, F_W, 32'h0000, 32'h0, 32'hCAFEF00D, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
